// File: rtl/branch_resolve_predict_d.sv
// Decode-stage branch resolver with a PC-indexed 2-bit counter predictor and perf counters.
// Resolution and mispredict are combinational (0 cycles); table/counter updates land on the next edge unless stalled.
module branch_resolve_predict_d #(
    parameter int         WIDTH    = 32,
    parameter int         IDX_BITS = 6,
    parameter int         CNT_W    = 16,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_F,
    output logic             pred_F,
    input  logic             valid_D,
    input  logic             stall_D,
    input  logic [WIDTH-1:0] pc_D,
    input  logic [2:0]       cmp_op,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    input  logic             pred_D,
    output logic             taken_D,
    output logic             mispredict_D,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    localparam int DEPTH = 1 << IDX_BITS;

    localparam logic [2:0] OP_BEQ    = 3'd0;
    localparam logic [2:0] OP_BNE    = 3'd1;
    localparam logic [2:0] OP_BGEZ   = 3'd2;
    localparam logic [2:0] OP_BGTZ   = 3'd3;
    localparam logic [2:0] OP_BLEZ   = 3'd4;
    localparam logic [2:0] OP_BLTZ   = 3'd5;
    localparam logic [2:0] OP_BGEZAL = 3'd6;
    localparam logic [2:0] OP_RSVD   = 3'd7;

    logic [DEPTH-1:0][1:0] tbl_q, tbl_d;
    logic [CNT_W-1:0]      branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]      miss_cnt_q, miss_cnt_d;

    logic [IDX_BITS-1:0]   idx_f, idx_d;
    logic                  rd1_neg, rd1_zero, taken_raw, op_ok, upd;
    logic                  unused_pc_bits;

    // Word-aligned PCs: bits [1:0] and everything above the index are deliberately ignored (aliasing allowed).
    assign idx_f          = pc_F[IDX_BITS+1:2];
    assign idx_d          = pc_D[IDX_BITS+1:2];
    assign unused_pc_bits = ^{pc_F, pc_D};

    assign pred_F = tbl_q[idx_f][1];

    assign rd1_neg  = rd1[WIDTH-1];
    assign rd1_zero = (rd1 == '0);

    always_comb begin
        taken_raw = 1'b0;
        case (cmp_op)
            OP_BEQ:              taken_raw = (rd1 == rd2);
            OP_BNE:              taken_raw = (rd1 != rd2);
            OP_BGEZ, OP_BGEZAL:  taken_raw = ~rd1_neg;
            OP_BGTZ:             taken_raw = ~rd1_neg & ~rd1_zero;
            OP_BLEZ:             taken_raw = rd1_neg | rd1_zero;
            OP_BLTZ:             taken_raw = rd1_neg;
            default:             taken_raw = 1'b0;
        endcase
    end

    assign op_ok        = (cmp_op != OP_RSVD);
    assign taken_D      = valid_D & taken_raw;
    assign mispredict_D = valid_D & op_ok & (taken_D != pred_D);
    assign upd          = valid_D & ~stall_D & op_ok;

    always_comb begin
        tbl_d        = tbl_q;
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (upd) begin
            if (taken_D) begin
                if (tbl_q[idx_d] != 2'b11)
                    tbl_d[idx_d] = tbl_q[idx_d] + 2'b01;
            end else begin
                if (tbl_q[idx_d] != 2'b00)
                    tbl_d[idx_d] = tbl_q[idx_d] - 2'b01;
            end
            if (branch_cnt_q != '1)
                branch_cnt_d = branch_cnt_q + CNT_W'(1);
            if (mispredict_D && (miss_cnt_q != '1))
                miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tbl_q        <= {DEPTH{CTR_INIT}};
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            tbl_q        <= tbl_d;
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign branch_cnt = branch_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_branch_resolve_predict_d.sv
// Directed bench for branch_resolve_predict_d with 4-bit perf counters so saturation is reachable.
module tb_branch_resolve_predict_d;
    localparam int W  = 32;
    localparam int IB = 6;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  pc_F;
    logic          pred_F;
    logic          valid_D;
    logic          stall_D;
    logic [W-1:0]  pc_D;
    logic [2:0]    cmp_op;
    logic [W-1:0]  rd1;
    logic [W-1:0]  rd2;
    logic          pred_D;
    logic          taken_D;
    logic          mispredict_D;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] miss_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int exp_br      = 0;
    int exp_miss    = 0;

    branch_resolve_predict_d #(
        .WIDTH(W), .IDX_BITS(IB), .CNT_W(CW), .CTR_INIT(2'b01)
    ) dut (
        .clk(clk), .reset(reset), .pc_F(pc_F), .pred_F(pred_F),
        .valid_D(valid_D), .stall_D(stall_D), .pc_D(pc_D), .cmp_op(cmp_op),
        .rd1(rd1), .rd2(rd2), .pred_D(pred_D), .taken_D(taken_D),
        .mispredict_D(mispredict_D), .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_branch_cnt"}, 32'(branch_cnt), exp_br);
        chk({tag, "_miss_cnt"}, 32'(miss_cnt), exp_miss);
    endtask

    task automatic br(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] pc, input logic pd);
        valid_D = 1'b1;
        cmp_op  = op;
        rd1     = a;
        rd2     = b;
        pc_D    = pc;
        pred_D  = pd;
        #1;
    endtask

    task automatic idle();
        valid_D = 1'b0;
        stall_D = 1'b0;
        #1;
    endtask

    // upd/miss: whether this edge is expected to update state and to count a mispredict
    task automatic tick(input bit upd, input bit m);
        @(posedge clk);
        if (upd) begin
            if (exp_br < 15) exp_br++;
            if (m && exp_miss < 15) exp_miss++;
        end
        #1;
    endtask

    initial begin
        reset = 1'b1; pc_F = '0; valid_D = 1'b0; stall_D = 1'b0; pc_D = '0;
        cmp_op = '0; rd1 = '0; rd2 = '0; pred_D = 1'b0;
        #12 reset = 1'b0;

        // 1: reset state and first mispredicting BEQ
        pc_F = 32'h3000; #1;
        chk("rst_pred_F", 32'(pred_F), 0);
        chk_cnt("rst");
        br(3'd0, 32'd5, 32'd5, 32'h3000, 1'b0);
        chk("t1_taken", 32'(taken_D), 1);
        chk("t1_misp", 32'(mispredict_D), 1);
        tick(1, 1);
        idle();
        chk("t1_pred_after", 32'(pred_F), 1);
        chk_cnt("t1");

        // 2: signed compares, held in stall so nothing updates
        stall_D = 1'b1;
        br(3'd5, 32'h8000_0000, '0, 32'h3004, 1'b0);
        chk("bltz_min_taken", 32'(taken_D), 1);
        chk("bltz_min_misp", 32'(mispredict_D), 1);
        br(3'd3, 32'h0, '0, 32'h3004, 1'b0);
        chk("bgtz_zero_taken", 32'(taken_D), 0);
        chk("bgtz_zero_misp", 32'(mispredict_D), 0);
        br(3'd4, 32'h0, '0, 32'h3004, 1'b0);
        chk("blez_zero_taken", 32'(taken_D), 1);
        br(3'd6, 32'h7FFF_FFFF, '0, 32'h3004, 1'b0);
        chk("bgezal_max_taken", 32'(taken_D), 1);
        br(3'd2, 32'h8000_0000, '0, 32'h3004, 1'b0);
        chk("bgez_neg_taken", 32'(taken_D), 0);
        br(3'd1, 32'd5, 32'd6, 32'h3004, 1'b0);
        chk("bne_taken", 32'(taken_D), 1);
        valid_D = 1'b0; #1;
        chk("invalid_taken", 32'(taken_D), 0);
        chk("invalid_misp", 32'(mispredict_D), 0);
        stall_D = 1'b0;
        br(3'd7, 32'd5, 32'd5, 32'h3004, 1'b1);
        chk("rsvd_taken", 32'(taken_D), 0);
        chk("rsvd_misp", 32'(mispredict_D), 0);
        tick(0, 0);
        idle();
        chk_cnt("rsvd");

        // 3: counter saturation at idx 1
        pc_F = 32'h3004;
        for (int i = 0; i < 5; i++) begin
            br(3'd0, 32'd5, 32'd5, 32'h3004, 1'b1);
            tick(1, 0);
            chk("sat_up_pred", 32'(pred_F), 1);
        end
        br(3'd0, 32'd1, 32'd2, 32'h3004, 1'b1);
        tick(1, 1);
        chk("sat_dn1_pred", 32'(pred_F), 1);
        tick(1, 1);
        chk("sat_dn2_pred", 32'(pred_F), 0);
        tick(1, 1);
        tick(1, 1);
        br(3'd0, 32'd5, 32'd5, 32'h3004, 1'b1);
        tick(1, 0);
        chk("sat_floor_up1_pred", 32'(pred_F), 0);
        tick(1, 0);
        chk("sat_floor_up2_pred", 32'(pred_F), 1);
        idle();
        chk_cnt("sat");

        // 4: stalled taken branch updates exactly once on release
        pc_F = 32'h3008;
        stall_D = 1'b1;
        br(3'd0, 32'd7, 32'd7, 32'h3008, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_taken", 32'(taken_D), 1);
            chk("stall_misp", 32'(mispredict_D), 1);
            tick(0, 0);
            chk("stall_pred", 32'(pred_F), 0);
            chk_cnt("stall");
        end
        stall_D = 1'b0; #1;
        tick(1, 1);
        idle();
        chk("release_pred", 32'(pred_F), 1);
        chk_cnt("release");
        tick(0, 0);
        chk_cnt("release_once");

        // 5: same-index read during write returns the old counter
        br(3'd0, 32'd1, 32'd2, 32'h3000, 1'b0);
        tick(1, 0);
        pc_F = 32'h3100;
        br(3'd0, 32'd3, 32'd3, 32'h3000, 1'b0);
        chk("hazard_pred_old", 32'(pred_F), 0);
        tick(1, 1);
        chk("hazard_pred_new", 32'(pred_F), 1);
        idle();
        chk_cnt("hazard");

        // 6: perf counter saturation then asynchronous reset
        for (int i = 0; i < 20; i++) begin
            br(3'd0, 32'd9, 32'd9, 32'h300C, 1'b0);
            tick(1, 1);
        end
        idle();
        chk("sat_branch_cnt", 32'(branch_cnt), 15);
        chk("sat_miss_cnt", 32'(miss_cnt), 15);
        chk_cnt("cnt_sat");
        #2 reset = 1'b1;
        #1;
        exp_br = 0; exp_miss = 0;
        chk_cnt("async_rst");
        for (int i = 0; i < (1 << IB); i++) begin
            pc_F = 32'h3000 + 32'(i << 2);
            #1;
            chk("async_rst_pred", 32'(pred_F), 0);
        end
        br(3'd0, 32'd1, 32'd2, 32'h3004, 1'b0);
        @(posedge clk);
        #2 reset = 1'b0;
        idle();
        br(3'd0, 32'd1, 32'd2, 32'h300C, 1'b0);
        tick(1, 0);
        idle();
        pc_F = 32'h300C; #1;
        chk("post_rst_300c_pred", 32'(pred_F), 0);
        br(3'd0, 32'd4, 32'd4, 32'h3004, 1'b1);
        tick(1, 0);
        idle();
        pc_F = 32'h3004; #1;
        chk("post_rst_3004_pred", 32'(pred_F), 1);
        chk_cnt("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish, expected finish by 50000");
        $fatal(1, "timeout");
    end

endmodule
